// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's MEM stage: word RAM plus a 32-byte MMIO
// window (cycle counter, LEDs, console TX FIFO, status). Reads are combinational.
module data_mem_responder #(
  parameter int          DEPTH_WORDS   = 1024,
  parameter int          TX_FIFO_DEPTH = 16,
  parameter logic [31:0] MMIO_BASE     = 32'h8000_0000,
  parameter string       INIT_FILE     = ""
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_data_mem_addr,
  input  logic [31:0] i_data_mem_write_data,
  input  logic        i_data_mem_read_en,
  input  logic        i_data_mem_write_en,
  input  logic [1:0]  i_data_mem_data_mask,
  output logic [31:0] o_data_mem_read_data,
  output logic [7:0]  o_led,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_bus_err,
  input  logic        i_err_clear
);

  localparam int                RAM_AW    = $clog2(DEPTH_WORDS);
  localparam int                FIFO_AW   = $clog2(TX_FIFO_DEPTH);
  localparam logic [31:0]       RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [FIFO_AW:0]  FIFO_FULL = (FIFO_AW + 1)'(TX_FIFO_DEPTH);

  localparam logic [2:0] REG_CYC_LO = 3'd0;
  localparam logic [2:0] REG_CYC_HI = 3'd1;
  localparam logic [2:0] REG_LED    = 3'd2;
  localparam logic [2:0] REG_TX     = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  logic [31:0] mem [DEPTH_WORDS];
  logic [7:0]  fifo_mem [TX_FIFO_DEPTH];

  // Control state
  logic [63:0]        cnt;
  logic [31:0]        hi_snap;
  logic [7:0]         led;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic               bus_err;

  // Decode
  logic [31:0]       mmio_off;
  logic              ram_hit;
  logic              mmio_hit;
  logic              is_byte;
  logic              is_half;
  logic              is_word;
  logic              misaligned;
  logic              access;
  logic              err_acc;
  logic [RAM_AW-1:0] ram_idx;
  logic [2:0]        reg_sel;

  // Unsigned wrap makes the window test correct even for a base near the top of memory.
  assign mmio_off   = i_data_mem_addr - MMIO_BASE;
  assign ram_hit    = i_data_mem_addr < RAM_BYTES;
  assign mmio_hit   = mmio_off < 32'd32;
  assign is_byte    = (i_data_mem_data_mask == 2'b00);
  assign is_half    = (i_data_mem_data_mask == 2'b01);
  assign is_word    = i_data_mem_data_mask[1];
  assign misaligned = (is_half & i_data_mem_addr[0]) |
                      (is_word & (i_data_mem_addr[1:0] != 2'b00));
  assign access     = i_data_mem_read_en | i_data_mem_write_en;
  assign err_acc    = access & (misaligned | ~(ram_hit | mmio_hit) | (mmio_hit & ~is_word));
  assign ram_idx    = i_data_mem_addr[RAM_AW+1:2];
  assign reg_sel    = mmio_off[4:2];

  // Strobes
  logic mmio_we;
  logic ram_we;
  logic led_we;
  logic push_req;
  logic push;
  logic pop;
  logic ovf_set;
  logic snap_lo;
  logic fifo_full;
  logic fifo_empty;

  assign ram_we     = i_data_mem_write_en & ~err_acc & ram_hit;
  assign mmio_we    = i_data_mem_write_en & ~err_acc & mmio_hit;
  assign led_we     = mmio_we & (reg_sel == REG_LED);
  assign push_req   = mmio_we & (reg_sel == REG_TX);
  assign fifo_full  = (count == FIFO_FULL);
  assign fifo_empty = (count == '0);
  assign push       = push_req & ~fifo_full;
  assign ovf_set    = push_req & fifo_full;
  assign pop        = o_tx_valid & i_tx_ready;
  assign snap_lo    = i_data_mem_read_en & ~err_acc & mmio_hit & (reg_sel == REG_CYC_LO);

  // Combinational read path
  logic [31:0] ram_word;
  logic [31:0] ram_rd;
  logic [31:0] mmio_rd;

  always_comb begin
    ram_word = mem[ram_idx];
    ram_rd   = ram_word;
    if (is_byte) begin
      ram_rd = {24'b0, ram_word[{i_data_mem_addr[1:0], 3'b000} +: 8]};
    end else if (is_half) begin
      ram_rd = {16'b0, (i_data_mem_addr[1] ? ram_word[31:16] : ram_word[15:0])};
    end
  end

  always_comb begin
    mmio_rd = '0;
    case (reg_sel)
      REG_CYC_LO: mmio_rd = cnt[31:0];
      REG_CYC_HI: mmio_rd = hi_snap;
      REG_LED:    mmio_rd = {24'b0, led};
      REG_STATUS: mmio_rd = {16'b0, 8'(count), 5'b0, overflow, fifo_empty, fifo_full};
      default:    mmio_rd = '0;
    endcase
  end

  assign o_data_mem_read_data = (i_data_mem_read_en & ~err_acc) ?
                                (ram_hit ? ram_rd : mmio_rd) : 32'b0;

  // Store lane steering
  logic [31:0] wr_lanes;
  logic [3:0]  wr_be;

  always_comb begin
    wr_lanes = i_data_mem_write_data;
    wr_be    = 4'b1111;
    if (is_byte) begin
      wr_lanes = {4{i_data_mem_write_data[7:0]}};
      wr_be    = 4'b0001 << i_data_mem_addr[1:0];
    end else if (is_half) begin
      wr_lanes = {2{i_data_mem_write_data[15:0]}};
      wr_be    = i_data_mem_addr[1] ? 4'b1100 : 4'b0011;
    end
  end

  // RAM and FIFO storage are never reset; contents survive rstn.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we && wr_be[b]) begin
        mem[ram_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= i_data_mem_write_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      hi_snap  <= '0;
      led      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      cnt <= cnt + 64'd1;
      if (snap_lo) begin
        hi_snap <= cnt[63:32];
      end
      if (led_we) begin
        led <= i_data_mem_write_data[7:0];
      end
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
      // A fresh error in the clearing cycle keeps its flag set.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (i_err_clear) begin
        overflow <= 1'b0;
      end
      if (err_acc) begin
        bus_err <= 1'b1;
      end else if (i_err_clear) begin
        bus_err <= 1'b0;
      end
    end
  end

  assign o_led      = led;
  assign o_bus_err  = bus_err;
  assign o_tx_valid = ~fifo_empty;
  assign o_tx_data  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM lanes, alignment errors, cycle
// counter snapshot, console FIFO, LED register and reset behaviour.
module tb_data_mem_responder;

  localparam logic [31:0] MB = 32'h8000_0000;
  localparam logic [1:0]  SZ_B = 2'b00;
  localparam logic [1:0]  SZ_H = 2'b01;
  localparam logic [1:0]  SZ_W = 2'b10;

  logic        clk;
  logic        rstn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        re;
  logic        we;
  logic [1:0]  mask;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_err;
  logic        err_clear;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_responder dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .i_data_mem_addr       (addr),
    .i_data_mem_write_data (wdata),
    .i_data_mem_read_en    (re),
    .i_data_mem_write_en   (we),
    .i_data_mem_data_mask  (mask),
    .o_data_mem_read_data  (rdata),
    .o_led                 (led),
    .o_tx_data             (tx_data),
    .o_tx_valid            (tx_valid),
    .i_tx_ready            (tx_ready),
    .o_bus_err             (bus_err),
    .i_err_clear           (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
    @(negedge clk);
    addr = a; wdata = d; mask = m; we = 1'b1; re = 1'b0;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [1:0] m, output logic [31:0] d);
    @(negedge clk);
    addr = a; mask = m; re = 1'b1; we = 1'b0;
    #1 d = rdata;
    @(posedge clk);
    #1 re = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rstn = 1'b0;
    #12;
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); end
    n_tests++; if (led !== 8'h00) begin n_fail++; $display("FAIL rst_led: got %h expected 00", led); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_bus_err: got %b expected 0", bus_err); end
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata_idle: got %h expected 0", rdata); end
    addr = MB + 32'h10; mask = SZ_W; re = 1'b1;
    #1 d = rdata;
    re = 1'b0;
    n_tests++; if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL rst_status: got %h expected 00000002", d); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_ram_lanes();
    logic [31:0] d;
    bus_write(32'h10, 32'hDEAD_BEEF, SZ_W);
    bus_write(32'h12, 32'h0000_0055, SZ_B);
    bus_read(32'h10, SZ_W, d);
    n_tests++; if (d !== 32'hDE55_BEEF) begin n_fail++; $display("FAIL ram_word: got %h expected DE55BEEF", d); end
    bus_read(32'h12, SZ_H, d);
    n_tests++; if (d !== 32'h0000_DE55) begin n_fail++; $display("FAIL ram_half_hi: got %h expected 0000DE55", d); end
    bus_read(32'h13, SZ_B, d);
    n_tests++; if (d !== 32'h0000_00DE) begin n_fail++; $display("FAIL ram_byte3: got %h expected 000000DE", d); end
    bus_read(32'h10, SZ_B, d);
    n_tests++; if (d !== 32'h0000_00EF) begin n_fail++; $display("FAIL ram_byte0: got %h expected 000000EF", d); end
    bus_write(32'h20, 32'h1122_3344, SZ_W);
    bus_write(32'h22, 32'hFFFF_A5C3, SZ_H);
    bus_read(32'h20, SZ_W, d);
    n_tests++; if (d !== 32'hA5C3_3344) begin n_fail++; $display("FAIL ram_half_write: got %h expected A5C33344", d); end
    @(negedge clk);
    addr = 32'h10; mask = SZ_W; re = 1'b0;
    #1 d = rdata;
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL ram_read_disabled: got %h expected 0", d); end
    // Read and write in the same cycle: read returns the old word.
    @(negedge clk);
    addr = 32'h20; wdata = 32'h0BAD_F00D; mask = SZ_W; re = 1'b1; we = 1'b1;
    #1 d = rdata;
    @(posedge clk);
    #1 re = 1'b0; we = 1'b0;
    n_tests++; if (d !== 32'hA5C3_3344) begin n_fail++; $display("FAIL ram_rd_wr_same: got %h expected A5C33344", d); end
    bus_read(32'h20, SZ_W, d);
    n_tests++; if (d !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL ram_rd_wr_commit: got %h expected 0BADF00D", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    bus_write(32'h00, 32'h1122_3344, SZ_W);
    bus_read(32'h11, SZ_W, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL err_misaligned_rdata: got %h expected 0", d); end
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_misaligned_flag: got %b expected 1", bus_err); end
    pulse_clear();
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", bus_err); end
    bus_write(32'h03, 32'h0000_BEEF, SZ_H);
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_half_write_flag: got %b expected 1", bus_err); end
    bus_read(32'h00, SZ_W, d);
    n_tests++; if (d !== 32'h1122_3344) begin n_fail++; $display("FAIL err_write_suppressed: got %h expected 11223344", d); end
    pulse_clear();
    bus_read(32'h4000_0000, SZ_W, d);
    n_tests++; if (d !== 32'h0 || bus_err !== 1'b1) begin n_fail++; $display("FAIL err_unmapped: got %h/%b expected 0/1", d, bus_err); end
    pulse_clear();
    // Error access in the clearing cycle keeps the flag set.
    @(negedge clk);
    addr = 32'h11; mask = SZ_W; re = 1'b1; err_clear = 1'b1;
    @(posedge clk);
    #1 re = 1'b0; err_clear = 1'b0;
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_clear_collision: got %b expected 1", bus_err); end
    pulse_clear();
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL err_clear_after: got %b expected 0", bus_err); end
  endtask

  task automatic test_cycle_counter();
    logic [31:0] d;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (100) @(posedge clk);
    bus_read(MB + 32'h00, SZ_W, d);
    n_tests++; if (d !== 32'd100) begin n_fail++; $display("FAIL cyc_lo: got %0d expected 100", d); end
    bus_read(MB + 32'h04, SZ_W, d);
    n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL cyc_hi: got %h expected 0", d); end
    @(negedge clk);
    force dut.cnt = 64'h0000_0000_FFFF_FFFC;
    #1 release dut.cnt;
    bus_read(MB + 32'h00, SZ_W, d);
    n_tests++; if (d !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL cyc_lo_near_wrap: got %h expected FFFFFFFD", d); end
    repeat (4) @(posedge clk);
    bus_read(MB + 32'h04, SZ_W, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL cyc_hi_snapshot: got %h expected 0", d); end
    bus_read(MB + 32'h00, SZ_W, d);
    n_tests++; if (d !== 32'h0000_0003) begin n_fail++; $display("FAIL cyc_lo_wrapped: got %h expected 00000003", d); end
    bus_read(MB + 32'h04, SZ_W, d);
    n_tests++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL cyc_hi_new_snap: got %h expected 00000001", d); end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] d;
    int bad;
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) bus_write(MB + 32'h0C, i, SZ_W);
    bus_read(MB + 32'h10, SZ_W, d);
    n_tests++; if (d !== 32'h0000_1005) begin n_fail++; $display("FAIL fifo_status_full: got %h expected 00001005", d); end
    n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin n_fail++; $display("FAIL fifo_head: got %b/%h expected 1/00", tx_valid, tx_data); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      #1;
      if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        bad++;
        $display("FAIL fifo_drain[%0d]: got %b/%h expected 1/%h", i, tx_valid, tx_data, 8'(i));
      end
    end
    n_tests++; if (bad != 0) n_fail++;
    @(negedge clk);
    tx_ready = 1'b0;
    #1;
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_drained_valid: got %b expected 0", tx_valid); end
    bus_read(MB + 32'h10, SZ_W, d);
    n_tests++; if (d !== 32'h0000_0006) begin n_fail++; $display("FAIL fifo_status_empty_ovf: got %h expected 00000006", d); end
    pulse_clear();
    bus_read(MB + 32'h10, SZ_W, d);
    n_tests++; if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL fifo_ovf_clear: got %h expected 00000002", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    tx_ready = 1'b0;
    bus_write(MB + 32'h08, 32'h0000_003C, SZ_W);
    bus_write(MB + 32'h0C, 32'hA1, SZ_W);
    bus_write(MB + 32'h0C, 32'hA2, SZ_W);
    bus_write(MB + 32'h0C, 32'hA3, SZ_W);
    @(negedge clk);
    addr = MB + 32'h0C; wdata = 32'hA4; mask = SZ_W; we = 1'b1; tx_ready = 1'b1;
    @(posedge clk);
    #1 we = 1'b0; tx_ready = 1'b0;
    bus_read(MB + 32'h10, SZ_W, d);
    n_tests++; if (d !== 32'h0000_0300) begin n_fail++; $display("FAIL b2b_count: got %h expected 00000300", d); end
    n_tests++; if (tx_data !== 8'hA2) begin n_fail++; $display("FAIL b2b_head: got %h expected A2", tx_data); end
    @(negedge clk);
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (tx_data !== 8'hA3 || led !== 8'h3C) begin n_fail++; $display("FAIL b2b_next: got %h/%h expected A3/3C", tx_data, led); end
    rstn = 1'b0;
    #1;
    n_tests++; if (tx_valid !== 1'b0 || led !== 8'h00) begin n_fail++; $display("FAIL b2b_async_reset: got %b/%h expected 0/00", tx_valid, led); end
    @(negedge clk);
    tx_ready = 1'b0;
    rstn = 1'b1;
    bus_read(32'h10, SZ_W, d);
    n_tests++; if (d !== 32'hDE55_BEEF) begin n_fail++; $display("FAIL b2b_ram_retained: got %h expected DE55BEEF", d); end
    bus_read(MB + 32'h10, SZ_W, d);
    n_tests++; if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL b2b_status_after_reset: got %h expected 00000002", d); end
  endtask

  task automatic test_led();
    logic [31:0] d;
    bus_write(MB + 32'h08, 32'h0000_01A5, SZ_W);
    n_tests++; if (led !== 8'hA5) begin n_fail++; $display("FAIL led_out: got %h expected A5", led); end
    bus_read(MB + 32'h08, SZ_W, d);
    n_tests++; if (d !== 32'h0000_00A5) begin n_fail++; $display("FAIL led_read: got %h expected 000000A5", d); end
    bus_write(MB + 32'h08, 32'h0000_0077, SZ_B);
    n_tests++; if (led !== 8'hA5 || bus_err !== 1'b1) begin n_fail++; $display("FAIL led_byte_write: got %h/%b expected A5/1", led, bus_err); end
    pulse_clear();
    bus_write(MB + 32'h00, 32'h1234_5678, SZ_W);
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL ro_write_no_err: got %b expected 0", bus_err); end
    bus_read(MB + 32'h14, SZ_W, d);
    n_tests++; if (d !== 32'h0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL reserved_read: got %h/%b expected 0/0", d, bus_err); end
    bus_read(MB + 32'h0C, SZ_W, d);
    n_tests++; if (d !== 32'h0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_reg_read: got %h/%b expected 0/0", d, tx_valid); end
  endtask

  initial begin
    addr = '0; wdata = '0; re = 1'b0; we = 1'b0; mask = SZ_W;
    tx_ready = 1'b0; err_clear = 1'b0;
    test_reset();
    test_ram_lanes();
    test_errors();
    test_cycle_counter();
    test_fifo_overflow();
    test_back_to_back();
    test_led();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
